// File: rtl/mmu_ctrl_pkg.sv
// mmu_ctrl_pkg: shared FSM state, memory request type and sizing defaults
package mmu_ctrl_pkg;
    localparam int ICACHE_LINES_DEF = 16;
    localparam int NUM_TRD_DEF = 8;
    typedef enum logic [1:0] {IDLE, I_FILL, D_ACC} state_t;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/mmu_ctrl_if.sv
// mmu_ctrl_if: core I/D ports, segment config and backing memory bus
interface mmu_ctrl_if;
    logic [31:0] i_addr, i_rd_data;
    logic        i_rd, i_miss, i_segfault;
    logic [2:0]  i_trd;
    logic [31:0] d_addr, d_wr_data, d_rd_data;
    logic        d_rd, d_wr, d_miss, d_segfault;
    logic [2:0]  d_trd;
    logic        seg_wr;
    logic [2:0]  seg_trd;
    logic [31:0] seg_base, seg_limit;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    modport slave (
        input  i_addr, i_rd, i_trd, d_addr, d_wr_data, d_rd, d_wr, d_trd,
               seg_wr, seg_trd, seg_base, seg_limit, m_ack, m_rdata,
        output i_rd_data, i_miss, i_segfault, d_rd_data, d_miss, d_segfault,
               m_req, m_we, m_addr, m_wdata
    );
    modport master (
        output i_addr, i_rd, i_trd, d_addr, d_wr_data, d_rd, d_wr, d_trd,
               seg_wr, seg_trd, seg_base, seg_limit, m_ack, m_rdata,
        input  i_rd_data, i_miss, i_segfault, d_rd_data, d_miss, d_segfault,
               m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mmu_seg_table.sv
// mmu_seg_table: per-thread base/limit registers with I and D lookup ports
module mmu_seg_table #(
    parameter int NUM_TRD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [2:0]  wr_trd,
    input  logic [31:0] wr_base,
    input  logic [31:0] wr_limit,
    input  logic [2:0]  i_trd,
    input  logic [31:0] i_addr,
    input  logic [2:0]  d_trd,
    input  logic [31:0] d_addr,
    output logic [31:0] i_phys,
    output logic        i_fault,
    output logic [31:0] d_phys,
    output logic        d_fault
);
    logic [31:0] base [NUM_TRD];
    logic [31:0] limit [NUM_TRD];
    always_ff @(posedge clk)
        if (rst)
            for (int t = 0; t < NUM_TRD; t++) begin
                base[t] <= '0;
                limit[t] <= '1;
            end
        else if (wr) begin
            base[wr_trd] <= wr_base;
            limit[wr_trd] <= wr_limit;
        end
    assign i_phys = base[i_trd] + i_addr;
    assign i_fault = i_addr > limit[i_trd];
    assign d_phys = base[d_trd] + d_addr;
    assign d_fault = d_addr > limit[d_trd];
endmodule

// File: rtl/mmu_ctrl.sv
// mmu_ctrl: segment MMU with direct-mapped I-cache and uncached replayed D-port
module mmu_ctrl
    import mmu_ctrl_pkg::*;
#(
    parameter int ICACHE_LINES = ICACHE_LINES_DEF,
    parameter int NUM_TRD = NUM_TRD_DEF
) (
    input logic clk,
    input logic rst,
    mmu_ctrl_if.slave bus
);
    localparam int IW = $clog2(ICACHE_LINES);
    localparam int TW = 30 - IW;
    logic [31:0] i_phys, d_phys;
    logic i_fault, d_fault;
    mmu_seg_table #(.NUM_TRD(NUM_TRD)) u_seg (
        .clk(clk), .rst(rst),
        .wr(bus.seg_wr), .wr_trd(bus.seg_trd), .wr_base(bus.seg_base), .wr_limit(bus.seg_limit),
        .i_trd(bus.i_trd), .i_addr(bus.i_addr), .d_trd(bus.d_trd), .d_addr(bus.d_addr),
        .i_phys(i_phys), .i_fault(i_fault), .d_phys(d_phys), .d_fault(d_fault)
    );
    logic [31:0] line_data [ICACHE_LINES];
    logic [TW-1:0] line_tag [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] line_v;
    state_t state;
    mem_req_t mreq;
    logic m_req;
    logic [31:0] i_rd_data, d_rd_data;
    logic i_miss, i_segfault, d_miss, d_segfault;
    logic done_v, done_we;
    logic [2:0] done_trd, pend_trd;
    logic [31:0] done_addr, done_data, pend_addr;
    logic [IW-1:0] i_idx;
    logic i_hit, d_req, d_match, d_go, i_go, ack;
    assign i_idx = i_phys[2 +: IW];
    assign i_hit = line_v[i_idx] && line_tag[i_idx] == i_phys[31 -: TW];
    assign d_req = bus.d_rd || bus.d_wr;
    assign d_match = done_v && done_trd == bus.d_trd && done_addr == bus.d_addr && done_we == bus.d_wr;
    // D-side misses win the single memory port over a concurrent I-miss
    assign d_go = state == IDLE && d_req && !d_fault && !d_match;
    assign i_go = state == IDLE && bus.i_rd && !i_fault && !i_hit && !d_go;
    assign ack = state != IDLE && bus.m_ack;
    always_ff @(posedge clk)
        if (!rst && state == I_FILL && bus.m_ack) begin
            line_data[mreq.addr[2 +: IW]] <= bus.m_rdata;
            line_tag[mreq.addr[2 +: IW]] <= mreq.addr[31 -: TW];
        end
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            m_req <= 1'b0;
            mreq <= '0;
            line_v <= '0;
            {i_rd_data, i_miss, i_segfault, d_rd_data, d_miss, d_segfault} <= '0;
            {done_v, done_we, done_trd, done_addr, done_data, pend_trd, pend_addr} <= '0;
        end else begin
            i_segfault <= bus.i_rd && i_fault;
            i_miss <= bus.i_rd && !i_fault && !i_hit;
            i_rd_data <= bus.i_rd && !i_fault && i_hit ? line_data[i_idx] : '0;
            d_segfault <= d_req && d_fault;
            d_miss <= d_req && !d_fault && !d_match;
            d_rd_data <= d_req && !d_fault && d_match && !bus.d_wr ? done_data : '0;
            if (d_req && !d_fault && d_match)
                done_v <= 1'b0;
            if (ack) begin
                state <= IDLE;
                m_req <= 1'b0;
                if (state == I_FILL)
                    line_v[mreq.addr[2 +: IW]] <= 1'b1;
                else
                    {done_v, done_we, done_trd, done_addr, done_data} <= {1'b1, mreq.we, pend_trd, pend_addr, bus.m_rdata};
            end else if (d_go) begin
                state <= D_ACC;
                m_req <= 1'b1;
                mreq <= '{we: bus.d_wr, addr: d_phys, wdata: bus.d_wr_data};
                {pend_trd, pend_addr} <= {bus.d_trd, bus.d_addr};
                done_v <= 1'b0;
            end else if (i_go) begin
                state <= I_FILL;
                m_req <= 1'b1;
                mreq <= '{we: 1'b0, addr: i_phys, wdata: 32'h0};
            end
            if (bus.seg_wr) begin
                line_v <= '0;
                done_v <= 1'b0;
            end
        end
    assign bus.i_rd_data = i_rd_data;
    assign bus.i_miss = i_miss;
    assign bus.i_segfault = i_segfault;
    assign bus.d_rd_data = d_rd_data;
    assign bus.d_miss = d_miss;
    assign bus.d_segfault = d_segfault;
    assign bus.m_req = m_req;
    assign bus.m_we = mreq.we;
    assign bus.m_addr = mreq.addr;
    assign bus.m_wdata = mreq.wdata;
endmodule

// File: tb/tb_mmu_ctrl.sv
// tb_mmu_ctrl: directed scenarios plus random traffic against a transaction-level model
module tb_mmu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mmu_ctrl_if bus();
    mmu_ctrl #(.ICACHE_LINES(16), .NUM_TRD(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_chk = 0, n_fail = 0;
    logic [31:0] base [8], limit [8];
    bit cv [16];
    logic [29:0] cword [16];
    logic [31:0] cdata [16];
    bit busy, busy_d, r_we, bv, bwe;
    logic [31:0] r_addr, r_wdata, r_va, baddr, bdata;
    logic [2:0] r_trd, btrd;
    logic [31:0] mem [logic [31:0]];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a * 32'h9E37_79B1 + 32'd1;
    endfunction
    task automatic model_reset();
        for (int t = 0; t < 8; t++) begin
            base[t] = 0;
            limit[t] = 32'hFFFF_FFFF;
        end
        for (int k = 0; k < 16; k++) cv[k] = 0;
        busy = 0;
        bv = 0;
    endtask
    task automatic step(input bit ird, input logic [31:0] ia, input logic [2:0] it,
                        input bit drd, input bit dwr, input logic [31:0] da, input logic [31:0] dwd,
                        input logic [2:0] dt, input bit sw, input logic [2:0] st,
                        input logic [31:0] sb, input logic [31:0] sl, input bit ack);
        logic [31:0] ip, dp, rdata;
        bit ifl, ihit, dreq, dfl, dm, dgo, igo;
        int ix, fx;
        rdata = (busy && !r_we) ? mem_rd(r_addr) : $urandom;
        bus.i_rd = ird; bus.i_addr = ia; bus.i_trd = it;
        bus.d_rd = drd; bus.d_wr = dwr; bus.d_addr = da; bus.d_wr_data = dwd; bus.d_trd = dt;
        bus.seg_wr = sw; bus.seg_trd = st; bus.seg_base = sb; bus.seg_limit = sl;
        bus.m_ack = ack; bus.m_rdata = rdata;
        ip = base[it] + ia;
        ifl = ia > limit[it];
        ix = int'((ip >> 2) % 32'd16);
        ihit = cv[ix] && cword[ix] == ip[31:2];
        dp = base[dt] + da;
        dfl = da > limit[dt];
        dreq = drd || dwr;
        dm = bv && btrd == dt && baddr == da && bwe == dwr;
        dgo = !busy && dreq && !dfl && !dm;
        igo = !busy && ird && !ifl && !ihit && !dgo;
        @(posedge clk);
        #1;
        chk("i_miss", bus.i_miss, ird && !ifl && !ihit);
        chk("i_segfault", bus.i_segfault, ird && ifl);
        if (ird && (ifl || ihit)) chk("i_rd_data", bus.i_rd_data, ifl ? 32'h0 : cdata[ix]);
        chk("d_miss", bus.d_miss, dreq && !dfl && !dm);
        chk("d_segfault", bus.d_segfault, dreq && dfl);
        if (dreq && (dfl || (dm && !dwr))) chk("d_rd_data", bus.d_rd_data, dfl ? 32'h0 : bdata);
        if (dreq && !dfl && dm) bv = 0;
        if (busy && ack) begin
            busy = 0;
            if (busy_d) begin
                {bv, bwe, btrd, baddr, bdata} = {1'b1, r_we, r_trd, r_va, rdata};
                if (r_we) mem[r_addr] = r_wdata;
            end else begin
                fx = int'((r_addr >> 2) % 32'd16);
                cv[fx] = 1;
                cword[fx] = r_addr[31:2];
                cdata[fx] = rdata;
            end
        end else if (dgo) begin
            {busy, busy_d, r_we, r_addr, r_wdata, r_trd, r_va} = {2'b11, dwr, dp, dwd, dt, da};
            bv = 0;
        end else if (igo) begin
            {busy, busy_d, r_we, r_addr} = {3'b100, ip};
        end
        if (sw) begin
            base[st] = sb;
            limit[st] = sl;
            for (int k = 0; k < 16; k++) cv[k] = 0;
            bv = 0;
        end
        chk("m_req", bus.m_req, busy);
        if (busy) begin
            chk("m_we", bus.m_we, r_we);
            chk("m_addr", bus.m_addr, r_addr);
            if (r_we) chk("m_wdata", bus.m_wdata, r_wdata);
        end
    endtask
    task automatic idle(input bit ack);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ack);
    endtask
    task automatic fetch(input logic [31:0] a, input logic [2:0] t);
        step(1, a, t, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic dacc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t);
        step(0, 0, 0, rd, wr, a, wd, t, 0, 0, 0, 0, 0);
    endtask
    task automatic segw(input logic [2:0] t, input logic [31:0] b, input logic [31:0] l);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, t, b, l, 0);
    endtask
    task automatic do_reset();
        rst = 1;
        {bus.i_rd, bus.d_rd, bus.d_wr, bus.seg_wr, bus.m_ack} = '0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        chk("rst_flags", {bus.i_miss, bus.i_segfault, bus.d_miss, bus.d_segfault, bus.m_req, bus.m_we}, 0);
        chk("rst_i_data", bus.i_rd_data, 0);
        chk("rst_d_data", bus.d_rd_data, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_m_wdata", bus.m_wdata, 0);
    endtask
    initial begin
        bit ird, drd, dwr, sw;
        logic [31:0] da, dwd;
        logic [2:0] dt;
        logic [31:0] lims [3];
        lims[0] = 32'h7C; lims[1] = 32'hBC; lims[2] = 32'hFFFF_FFFF;
        do_reset();
        mem[32'h40] = 32'hDEAD_0001;
        fetch(32'h40, 0);
        chk("r25_miss", bus.i_miss, 1);
        chk("r25_maddr", bus.m_addr, 32'h40);
        idle(0); idle(0); idle(1);
        fetch(32'h40, 0);
        chk("r25_hit_data", bus.i_rd_data, 32'hDEAD_0001);
        chk("r25_hit_miss", bus.i_miss, 0);
        segw(2, 32'h1000, 32'hFF);
        dacc(1, 0, 32'h100, 0, 2);
        chk("r26_segfault", bus.d_segfault, 1);
        chk("r26_no_req", bus.m_req, 0);
        dacc(1, 0, 32'h10, 0, 2);
        chk("r26_maddr", bus.m_addr, 32'h1010);
        idle(1);
        segw(4, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        dacc(1, 0, 32'h20, 0, 4);
        chk("wrap_maddr", bus.m_addr, 32'h10);
        idle(1);
        segw(3, 0, 32'h7C);
        fetch(32'h7C, 3);
        chk("limit_edge_ok", bus.i_segfault, 0);
        fetch(32'h80, 3);
        chk("limit_edge_fault", bus.i_segfault, 1);
        idle(1);
        dacc(0, 1, 32'h20, 32'hCAFE, 0);
        chk("r27_wr_miss", bus.d_miss, 1);
        chk("r27_m_we", bus.m_we, 1);
        idle(1);
        dacc(0, 1, 32'h20, 32'hCAFE, 0);
        chk("r27_wr_replay", bus.d_miss, 0);
        dacc(1, 0, 32'h20, 0, 0);
        chk("r27_rd_miss", bus.d_miss, 1);
        idle(0); idle(1);
        dacc(1, 0, 32'h20, 0, 0);
        chk("r27_rd_replay", bus.d_miss, 0);
        chk("r27_rd_data", bus.d_rd_data, 32'hCAFE);
        step(1, 32'h200, 0, 1, 0, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        chk("r28_i_miss", bus.i_miss, 1);
        chk("r28_d_first", bus.m_addr, 32'h300);
        idle(1);
        chk("r28_i_dropped", bus.m_req, 0);
        fetch(32'h80, 0);
        chk("r29_fill", bus.m_req, 1);
        do_reset();
        idle(1);
        chk("r29_late_ack", bus.m_req, 0);
        fetch(32'h80, 0);
        chk("r29_refetch_miss", bus.i_miss, 1);
        {drd, dwr, da, dwd, dt} = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                drd = $urandom_range(0, 1) == 1;
                dwr = $urandom_range(0, 2) == 0;
                da = $urandom_range(0, 47) * 4;
                dwd = $urandom;
                dt = 3'($urandom_range(0, 3));
            end
            ird = $urandom_range(0, 9) < 6;
            sw = $urandom_range(0, 99) == 0;
            step(ird, $urandom_range(0, 47) * 4, 3'($urandom_range(0, 3)),
                 drd && $urandom_range(0, 9) < 7, dwr, da, dwd, dt,
                 sw, 3'($urandom_range(0, 3)), $urandom_range(0, 7) * 64, lims[$urandom_range(0, 2)],
                 busy && $urandom_range(0, 2) == 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmu_ctrl.md
MMU_CTRL -- requirements
Module: mmu_ctrl

Interface
REQ-001 SHALL have parameters: ICACHE_LINES = 16 (direct-mapped I-cache entries, one 32-bit word per line, power of two); NUM_TRD = 8 (thread contexts).
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk input 1 = rising-edge clock; rst input 1 = synchronous active-high reset.
REQ-003 SHALL have core I-port signals: i_addr in 32 = fetch address; i_rd in 1 = fetch request; i_trd in 3 = fetch thread; i_rd_data out 32 = instruction; i_miss out 1 = fetch not served; i_segfault out 1 = fetch out of segment.
REQ-004 SHALL have core D-port signals: d_addr in 32; d_wr_data in 32; d_rd in 1; d_wr in 1; d_trd in 3; d_rd_data out 32; d_miss out 1; d_segfault out 1.
REQ-005 SHALL have segment config signals: seg_wr in 1 = write strobe; seg_trd in 3; seg_base in 32; seg_limit in 32.
REQ-006 SHALL have backing memory signals: m_req out 1; m_we out 1; m_addr out 32; m_wdata out 32; m_ack in 1 = one-cycle completion; m_rdata in 32 = valid when m_ack=1.

Function
REQ-007 SHALL translate each access as phys = base[trd] + addr (mod 2^32), with fault when addr > limit[trd].
REQ-008 SHALL register all core-side responses: a request in cycle N gets its response (data/miss/segfault) in cycle N+1. With no request in cycle N, miss and segfault SHALL be 0 in N+1.
REQ-009 An I-hit SHALL give i_rd_data = line data, i_miss=0; a hit needs valid & tag match on phys, index = phys[5:2] for 16 lines.
REQ-010 An I-miss SHALL give i_miss=1 for one response cycle and start a fill if the FSM is IDLE. Otherwise the miss is dropped and the core re-fetches.
REQ-011 A faulting access SHALL give segfault=1, miss=0, data=0; it makes no memory request and no cache change.
REQ-012 The D-port SHALL be uncached, with a replay protocol. A first request gives d_miss=1 and launches the memory access. On m_ack, the result is kept in a done buffer tagged {trd, addr, rd/wr}. A later identical request gives d_miss=0 (read: d_rd_data = buffered data) and clears the buffer.
REQ-013 A D-request that differs from an occupied done buffer SHALL get d_miss=1; the buffer is discarded and the new access launched when the FSM is IDLE.
REQ-014 d_rd and d_wr both high SHALL be treated as a write.
REQ-015 The FSM SHALL have states IDLE, I_FILL and D_ACC. IDLE->D_ACC on a pending D-miss; otherwise IDLE->I_FILL on an I-miss (D has priority when both occur in the same cycle). I_FILL/D_ACC->IDLE on m_ack.
REQ-016 m_req, m_we, m_addr and m_wdata SHALL stay high/stable from state entry until the m_ack cycle inclusive; m_req=0 in IDLE.
REQ-017 An I_FILL completion SHALL write data, tag and valid to the line. A fetch of the filling line in the m_ack cycle SHALL still report a miss.
REQ-018 seg_wr SHALL update base/limit[seg_trd] at the next edge, and SHALL invalidate the whole I-cache and the done buffer in that same cycle.
REQ-019 Requests arriving while a memory access is in flight SHALL be answered (hit, fault or miss) without stalling the outstanding access.

Reset
REQ-020 rst SHALL clear all outputs to 0 and the FSM to IDLE, and SHALL clear all cache valid bits and the done buffer.
REQ-021 rst SHALL set base[t]=0 and limit[t]=32'hFFFF_FFFF for every thread.
REQ-022 rst asserted mid-access SHALL abandon the access: m_req=0 next cycle, and a later m_ack is ignored.

Structure
REQ-023 The shared package SHALL hold the FSM state enum, the memory-request struct {we, addr, wdata} and the ICACHE_LINES/NUM_TRD defaults.
REQ-024 The design SHALL have exactly one sub-module, mmu_seg_table: NUM_TRD base/limit registers with two combinational lookup ports (I, D) that return phys and fault.

Verification
REQ-025 Reset, then thread 0 fetches 0x40, with m_ack after 3 cycles returning 0xDEAD0001 -> i_miss=1, m_addr=0x40; a re-fetch after the fill gives i_rd_data=0xDEAD0001, i_miss=0.
REQ-026 Set thread 2 base=0x1000, limit=0xFF; d_rd 0x100 by thread 2 -> d_segfault=1, m_req stays 0. d_rd 0x10 -> m_addr=0x1010.
REQ-027 d_wr of 0xCAFE to 0x20 -> d_miss=1, m_we=1. After ack, replaying the same write gives d_miss=0; a d_rd of 0x20 returning 0xCAFE completes on its replay.
REQ-028 A simultaneous I-miss and D-miss in IDLE -> D_ACC is entered first, i_miss=1, and the I request is not launched.
REQ-029 Reset during I_FILL, then a late m_ack -> no line becomes valid, and the next fetch of that address misses.
